// File: rtl/core_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path.
package core_ctrl_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 7;

  typedef enum logic [STATE_W-1:0] {
    FETCH = 4'd0, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R,
    EXEC_I, ALU_WB, BRANCH, JAL, JALR, JALR_PC, LUI
  } state_t;

  typedef enum logic [1:0] {
    S_T = 2'b00, B_T = 2'b01, R_T = 2'b10, I_T = 2'b11
  } alu_op_t;

  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MDR    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the controller and the datapath.
interface multicycle_controller_if #(parameter int unsigned CNT_W = 32);
  logic [6:0]       op;
  logic [2:0]       func3;
  logic             zero;
  logic             alu_neg;
  logic             mem_ready;
  logic             pc_write;
  logic             adr_src;
  logic             mem_write;
  logic             mem_req;
  logic             ir_write;
  logic             reg_write;
  logic [1:0]       result_src;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [2:0]       imm_src;
  logic             illegal_op;
  logic             retire;
  logic [CNT_W-1:0] retired_cnt;
  logic [3:0]       state_dbg;

  modport master (
    input  op, func3, zero, alu_neg, mem_ready,
    output pc_write, adr_src, mem_write, mem_req, ir_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_op, imm_src,
           illegal_op, retire, retired_cnt, state_dbg
  );

  modport slave (
    output op, func3, zero, alu_neg, mem_ready,
    input  pc_write, adr_src, mem_write, mem_req, ir_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_op, imm_src,
           illegal_op, retire, retired_cnt, state_dbg
  );
endinterface

// File: rtl/branch_cond.sv
// Branch outcome from func3 and the ALU subtract flags.
module branch_cond (
  input  logic [2:0] func3,
  input  logic       zero,
  input  logic       alu_neg,
  output logic       taken,
  output logic       illegal
);
  // beq/bne use zero, blt/bge use the sign of rs1-rs2
  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (func3)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      3'b100:  taken = alu_neg;
      3'b101:  taken = ~alu_neg;
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/multicycle_controller.sv
// Main sequencing FSM of the multi-cycle RV32I core.
module multicycle_controller
  import core_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input logic clk,
  input logic rst,
  multicycle_controller_if.master bus
);

  state_t           state_q, state_n;
  logic [CNT_W-1:0] cnt_q;

  logic       br_taken, br_illegal;
  logic       pc_write_c, adr_src_c, mem_write_c, mem_req_c, ir_write_c;
  logic       reg_write_c, illegal_c, retire_c;
  logic [1:0] result_src_c, src_a_c, src_b_c;
  alu_op_t    alu_op_c;
  logic [2:0] imm_src_c;

  branch_cond u_branch_cond (
    .func3   (bus.func3),
    .zero    (bus.zero),
    .alu_neg (bus.alu_neg),
    .taken   (br_taken),
    .illegal (br_illegal)
  );

  // State register; reset abandons any in-flight instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_n;
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           cnt_q <= '0;
    else if (retire_c) cnt_q <= cnt_q + CNT_W'(1);
  end

  // Next state and per-state control outputs
  always_comb begin
    state_n      = state_q;
    pc_write_c   = 1'b0;
    adr_src_c    = 1'b0;
    mem_write_c  = 1'b0;
    mem_req_c    = 1'b0;
    ir_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    illegal_c    = 1'b0;
    retire_c     = 1'b0;
    result_src_c = RES_ALUOUT;
    src_a_c      = SRCA_PC;
    src_b_c      = SRCB_RS2;
    alu_op_c     = S_T;
    imm_src_c    = IMM_I;
    case (state_q)
      FETCH: begin
        mem_req_c    = 1'b1;
        src_b_c      = SRCB_FOUR;
        result_src_c = RES_ALU;
        ir_write_c   = bus.mem_ready;
        pc_write_c   = bus.mem_ready;
        if (bus.mem_ready) state_n = DECODE;
      end
      DECODE: begin
        src_a_c   = SRCA_OLDPC;
        src_b_c   = SRCB_IMM;
        imm_src_c = (bus.op == OP_JAL) ? IMM_J : IMM_B;
        case (bus.op)
          OP_LOAD, OP_STORE: state_n = MEM_ADR;
          OP_RTYPE:          state_n = EXEC_R;
          OP_ITYPE:          state_n = EXEC_I;
          OP_BRANCH:         state_n = BRANCH;
          OP_JAL:            state_n = JAL;
          OP_JALR:           state_n = JALR;
          OP_LUI:            state_n = LUI;
          default: begin
            illegal_c = 1'b1;
            state_n   = FETCH;
          end
        endcase
      end
      MEM_ADR: begin
        src_a_c = SRCA_RS1;
        src_b_c = SRCB_IMM;
        if (bus.op == OP_STORE) begin
          imm_src_c = IMM_S;
          state_n   = MEM_WRITE;
        end else begin
          state_n   = MEM_READ;
        end
      end
      MEM_READ: begin
        mem_req_c = 1'b1;
        adr_src_c = 1'b1;
        if (bus.mem_ready) state_n = MEM_WB;
      end
      MEM_WB: begin
        result_src_c = RES_MDR;
        reg_write_c  = 1'b1;
        retire_c     = 1'b1;
        state_n      = FETCH;
      end
      MEM_WRITE: begin
        mem_req_c   = 1'b1;
        mem_write_c = 1'b1;
        adr_src_c   = 1'b1;
        if (bus.mem_ready) begin
          retire_c = 1'b1;
          state_n  = FETCH;
        end
      end
      EXEC_R: begin
        src_a_c  = SRCA_RS1;
        alu_op_c = R_T;
        state_n  = ALU_WB;
      end
      EXEC_I: begin
        src_a_c  = SRCA_RS1;
        src_b_c  = SRCB_IMM;
        alu_op_c = I_T;
        state_n  = ALU_WB;
      end
      ALU_WB: begin
        reg_write_c = 1'b1;
        retire_c    = 1'b1;
        state_n     = FETCH;
      end
      BRANCH: begin
        src_a_c  = SRCA_RS1;
        alu_op_c = B_T;
        if (br_illegal) begin
          illegal_c = 1'b1;
        end else begin
          pc_write_c = br_taken;
          retire_c   = 1'b1;
        end
        state_n = FETCH;
      end
      JAL: begin
        pc_write_c = 1'b1;
        src_a_c    = SRCA_OLDPC;
        src_b_c    = SRCB_FOUR;
        state_n    = ALU_WB;
      end
      JALR: begin
        src_a_c = SRCA_RS1;
        src_b_c = SRCB_IMM;
        state_n = JALR_PC;
      end
      JALR_PC: begin
        pc_write_c = 1'b1;
        src_a_c    = SRCA_OLDPC;
        src_b_c    = SRCB_FOUR;
        state_n    = ALU_WB;
      end
      LUI: begin
        imm_src_c    = IMM_U;
        result_src_c = RES_IMM;
        reg_write_c  = 1'b1;
        retire_c     = 1'b1;
        state_n      = FETCH;
      end
      default: state_n = FETCH;
    endcase
    // Reset must suppress every side effect immediately, not at the next edge
    if (rst) begin
      pc_write_c  = 1'b0;
      mem_write_c = 1'b0;
      mem_req_c   = 1'b0;
      ir_write_c  = 1'b0;
      reg_write_c = 1'b0;
      illegal_c   = 1'b0;
      retire_c    = 1'b0;
    end
  end

  assign bus.pc_write    = pc_write_c;
  assign bus.adr_src     = adr_src_c;
  assign bus.mem_write   = mem_write_c;
  assign bus.mem_req     = mem_req_c;
  assign bus.ir_write    = ir_write_c;
  assign bus.reg_write   = reg_write_c;
  assign bus.result_src  = result_src_c;
  assign bus.alu_src_a   = src_a_c;
  assign bus.alu_src_b   = src_b_c;
  assign bus.alu_op      = alu_op_c;
  assign bus.imm_src     = imm_src_c;
  assign bus.illegal_op  = illegal_c;
  assign bus.retire      = retire_c;
  assign bus.retired_cnt = cnt_q;
  assign bus.state_dbg   = state_q;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main FSM for the multi-cycle RV32I core. It sequences the shared ALU, PC, instruction register and memory port through fetch, decode, execute, memory and writeback.
- Drives the 2-bit ALUOp consumed by ALU_Controller: 00 S_T (add), 01 B_T (sub), 10 R_T, 11 I_T.
- Stalls on a memory ready handshake and counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
op  in  7  instruction opcode, from IR
func3  in  3  instruction func3, from IR
zero  in  1  ALU result == 0
alu_neg  in  1  ALU result sign bit, for signed compare
mem_ready  in  1  memory access completes this cycle
pc_write  out  1  PC load enable
adr_src  out  1  memory address select: 0 PC, 1 ALUOut
mem_write  out  1  memory write request
mem_req  out  1  memory access request (fetch, load, store)
ir_write  out  1  IR and oldPC load enable
reg_write  out  1  register file write enable
result_src  out  2  result select: 00 ALUOut, 01 MDR, 10 ALU result, 11 immediate
alu_src_a  out  2  ALU A select: 00 PC, 01 oldPC, 10 rs1 register
alu_src_b  out  2  ALU B select: 00 rs2 register, 01 immediate, 10 constant 4
alu_op  out  2  ALUOp to ALU_Controller
imm_src  out  3  immediate type: 000 I, 001 S, 010 B, 011 J, 100 U
illegal_op  out  1  one-cycle pulse on an unsupported opcode or branch func3
retire  out  1  one-cycle pulse when an instruction completes
retired_cnt  out  CNT_W  retired-instruction count, wraps
state_dbg  out  4  current state encoding

Behaviour:
Reset and defaults:
- Asynchronous reset: state=FETCH, retired_cnt=0.
- While rst=1, pc_write, mem_write, mem_req, ir_write, reg_write, illegal_op and retire are forced 0.
- Outputs are Moore/Mealy combinational from state, op, func3, zero, alu_neg and mem_ready.
- Any output not listed for a state is 0 / 00 / 000.
- The next state is registered on the rising clk edge.

States and outputs:
- FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10. ir_write=pc_write=mem_ready. Hold while mem_ready=0; go to DECODE on mem_ready.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00, so ALUOut=oldPC+imm. imm_src=011 if op=1101111, else 010. Next state by op:
  - 0000011 or 0100011 -> MEM_ADR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - any other op -> FETCH with illegal_op=1 and no retire
- MEM_ADR: alu_src_a=10, alu_src_b=01, alu_op=00. imm_src=000 for a load, 001 for a store. Go to MEM_READ (load) or MEM_WRITE (store).
- MEM_READ: mem_req=1, adr_src=1. Hold until mem_ready, then MEM_WB.
- MEM_WB: result_src=01, reg_write=1, retire=1 -> FETCH.
- MEM_WRITE: mem_req=1, mem_write=1, adr_src=1. Hold until mem_ready; on that cycle retire=1 and go to FETCH.
- EXEC_R: alu_src_a=10, alu_src_b=00, alu_op=10 -> ALU_WB.
- EXEC_I: alu_src_a=10, alu_src_b=01, imm_src=000, alu_op=11 -> ALU_WB.
- ALU_WB: result_src=00, reg_write=1, retire=1 -> FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00.
  - Taken condition by func3: 000 zero, 001 !zero, 100 alu_neg, 101 !alu_neg.
  - pc_write=1 when taken.
  - Other func3 values: not taken, illegal_op=1, no retire.
  - Otherwise retire=1. Next state FETCH.
- JAL: result_src=00, pc_write=1 (PC=target from DECODE). alu_src_a=01, alu_src_b=10, alu_op=00, so ALUOut=oldPC+4. Next ALU_WB.
- JALR: alu_src_a=10, alu_src_b=01, imm_src=000, alu_op=00 -> JALR_PC.
- JALR_PC: result_src=00, pc_write=1, alu_src_a=01, alu_src_b=10, alu_op=00 -> ALU_WB.
- LUI: imm_src=100, result_src=11, reg_write=1, retire=1 -> FETCH.

Counter and reset corner cases:
- retired_cnt increments by 1 on each retire; wraps from 2^CNT_W-1 to 0.
- mem_ready outside FETCH, MEM_READ and MEM_WRITE is ignored.
- A reset asserted mid-instruction aborts it: no partial write, and FETCH restarts after release.

Latency in cycles, with mem_ready=1 immediately:
- R/I-type 4, load 5, store 4, branch 3, JAL 4, JALR 5, LUI 3.
- Each mem_ready=0 cycle adds one cycle.

Decomposition:
- Package core_ctrl_pkg holds:
  - state encodings (4-bit): FETCH=0, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, ALU_WB, BRANCH, JAL, JALR, JALR_PC, LUI
  - ALUOp codes S_T/B_T/R_T/I_T
  - opcode constants
  - mux select codes and imm_src codes
- One sub-module, branch_cond: combinational (func3, zero, alu_neg) -> taken, illegal.

Test Plan:
- add (op=0110011), mem_ready=1 -> states FETCH, DECODE, EXEC_R, ALU_WB; alu_op=10 in EXEC_R; reg_write=1 only in ALU_WB; retire pulse; retired_cnt 0->1.
- lw with mem_ready low 2 cycles in FETCH and 3 cycles in MEM_READ -> ir_write=1 exactly once; adr_src=1 during MEM_READ; completes in 10 cycles; result_src=01 in MEM_WB.
- beq with zero=1, then bne with zero=1 -> pc_write=1 then pc_write=0; alu_op=01 in BRANCH for both; 3 cycles each.
- jal -> imm_src=011 in DECODE; pc_write=1 in JAL; reg_write=1 with result_src=00 in ALU_WB; no reg_write in JAL.
- op=1111111, then branch func3=010 -> illegal_op pulse in DECODE and in BRANCH respectively; no retire; returns to FETCH.
- rst asserted asynchronously during MEM_WRITE with mem_ready=0 -> mem_write drops immediately; state_dbg=0; retired_cnt=0. CNT_W=4 with 16 retires -> count wraps to 0.
